key_reader: RTL
===============

KEY_READER -- requirements
Module: key_reader

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000; number of consecutive stable clocks (20 ms at 50 MHz) needed to accept a level change.
REQ-002 SHALL have parameter REPEAT_DELAY, default 25000000; clocks a key is held before the first auto-repeat pulse (used only with KEY_REPEAT_EN).
REQ-003 SHALL have parameter REPEAT_PERIOD, default 5000000; clocks between later auto-repeat pulses (used only with KEY_REPEAT_EN).
REQ-004 SHALL have port CLOCK_50  input  1  system clock, all logic on its rising edge.
REQ-005 SHALL have port RST_N  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port KEY  input  4  raw pushbuttons, active-low (0 = pressed), asynchronous to CLOCK_50.
REQ-007 SHALL have port KEY_LEVEL  output  4  debounced state per key, active-high (1 = pressed).
REQ-008 SHALL have port KEY_PRESS  output  4  one-clock pulse per accepted press, plus auto-repeat pulses.
REQ-009 SHALL have port KEY_RELEASE  output  4  one-clock pulse per accepted release.
REQ-010 SHALL have port LEDG  output  4  mirror of KEY_LEVEL for board display.

Function
REQ-011 SHALL pass each KEY bit through a 2-flop synchronizer; all later logic SHALL use only the synchronized value.
REQ-012 SHALL give each of the 4 channels an independent FSM with states RELEASED, CHK_PRESS, PRESSED, CHK_RELEASE.
REQ-013 In RELEASED, a synchronized 0 SHALL move the channel to CHK_PRESS and clear its counter.
REQ-014 In CHK_PRESS, the counter SHALL increment while the input stays 0; a 1 before DEBOUNCE_CYCLES SHALL return to RELEASED without an output change.
REQ-015 When the CHK_PRESS counter reaches DEBOUNCE_CYCLES-1 with input still 0, the channel SHALL enter PRESSED, set KEY_LEVEL, and pulse KEY_PRESS for exactly one clock.
REQ-016 CHK_RELEASE SHALL mirror CHK_PRESS for input 1; on completion it SHALL enter RELEASED, clear KEY_LEVEL, and pulse KEY_RELEASE for exactly one clock.
REQ-017 Latency from a clean KEY edge to the KEY_PRESS or KEY_RELEASE pulse SHALL be exactly 2 + DEBOUNCE_CYCLES clocks.
REQ-018 Each debounce counter SHALL be sized ceil(log2(max(DEBOUNCE_CYCLES, REPEAT_DELAY))) + 1 bits; compares SHALL be unsigned and counters SHALL saturate and never wrap.
REQ-019 Channels SHALL be fully independent; simultaneous events on several keys SHALL pulse all corresponding bits in the same clock.
REQ-020 KEY_PRESS and KEY_RELEASE SHALL never both be 1 for the same bit in the same clock.
REQ-021 LEDG SHALL equal KEY_LEVEL combinationally from the register, with no added latency.

Reset
REQ-022 RST_N low SHALL asynchronously force every FSM to RELEASED, clear all counters and synchronizer flops to the released value, and drive KEY_LEVEL, KEY_PRESS, KEY_RELEASE and LEDG to 0.
REQ-023 Reset asserted mid-debounce or mid-hold SHALL discard the event with no pulse; after release, a key still held SHALL go through the full debounce before KEY_PRESS.
REQ-024 Reset release SHALL take effect on the first CLOCK_50 rising edge after RST_N goes high.

Configuration
REQ-025 Macro KEY_REPEAT_EN defined: in PRESSED, after REPEAT_DELAY clocks held, KEY_PRESS SHALL pulse once, then once every REPEAT_PERIOD clocks until release debounce starts.
REQ-026 Macro KEY_REPEAT_EN undefined: the repeat counter and logic SHALL be absent, and KEY_PRESS SHALL pulse only once per press.

Verification (DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5)
REQ-027 Clean press: KEY[0] 1->0 and held -> KEY_PRESS[0] single pulse 10 clocks after the edge; KEY_LEVEL[0] and LEDG[0] go to 1 together.
REQ-028 Bounce: KEY[1] toggles every 3 clocks for 30 clocks, then stays 0 -> exactly one KEY_PRESS[1] pulse, 10 clocks after the last edge; no KEY_RELEASE[1].
REQ-029 Simultaneous: KEY[3:0] 1111->0000 in the same clock -> KEY_PRESS=4'b1111 for one clock; release gives KEY_RELEASE=4'b1111 for one clock.
REQ-030 Reset mid-operation: RST_N pulsed low during CHK_PRESS at count 5 -> all outputs 0 immediately with no pulse; key still held -> KEY_PRESS 10 clocks after RST_N goes high.
REQ-031 Repeat: KEY[2] held 60 clocks with KEY_REPEAT_EN defined -> pulses at debounce completion, +20, +25, +30...; with the macro undefined -> one pulse only.

Source files
------------

// File: rtl/key_reader.sv
// Four-channel pushbutton reader: 2-flop synchronizer, per-key debounce FSM,
// press/release pulses. Optional auto-repeat on KEY_PRESS under `KEY_REPEAT_EN.
module key_reader #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic       CLOCK_50,
  input  logic       RST_N,
  input  logic [3:0] KEY,
  output logic [3:0] KEY_LEVEL,
  output logic [3:0] KEY_PRESS,
  output logic [3:0] KEY_RELEASE,
  output logic [3:0] LEDG
);

  // One counter per channel serves both debounce and, while held, repeat timing.
  localparam int unsigned SPAN_DR = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int unsigned SPAN    = (SPAN_DR > REPEAT_PERIOD) ? SPAN_DR : REPEAT_PERIOD;
  localparam int unsigned CW      = $clog2(SPAN) + 1;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    CHK_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    CHK_RELEASE = 2'd3
  } state_t;

  logic [3:0] r_sync1;
  logic [3:0] r_sync2;

  // Synchronizer resets to the released (high) level of the raw buttons.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= KEY;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_chan
    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [CW-1:0]   w_cnt_inc;
    logic            r_level;
    logic            w_level_nxt;
    logic            r_press;
    logic            w_press_nxt;
    logic            r_rel;
    logic            w_rel_nxt;
    logic            w_in;
    logic            w_db_done;

    assign w_in      = r_sync2[g];
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
    // Entry into a check state is itself the first stable sample, so the
    // count completes one clock before r_cnt would read DEBOUNCE_CYCLES-1.
    assign w_db_done = (64'(r_cnt) + 64'd2) >= 64'(DEBOUNCE_CYCLES);

`ifdef KEY_REPEAT_EN
    logic r_rep_first;
    logic w_rep_first_nxt;
    logic w_rep_due;

    assign w_rep_due = (64'(r_cnt) + 64'd1) >=
                       (r_rep_first ? 64'(REPEAT_DELAY) : 64'(REPEAT_PERIOD));

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
      if (!RST_N) r_rep_first <= 1'b1;
      else        r_rep_first <= w_rep_first_nxt;
    end
`endif

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
      if (!RST_N) begin
        r_state <= RELEASED;
        r_cnt   <= '0;
        r_level <= 1'b0;
        r_press <= 1'b0;
        r_rel   <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_level <= w_level_nxt;
        r_press <= w_press_nxt;
        r_rel   <= w_rel_nxt;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_level_nxt = r_level;
      w_press_nxt = 1'b0;
      w_rel_nxt   = 1'b0;
`ifdef KEY_REPEAT_EN
      w_rep_first_nxt = r_rep_first;
`endif
      case (r_state)
        RELEASED: begin
          if (!w_in) begin
            w_state_nxt = CHK_PRESS;
            w_cnt_nxt   = '0;
          end
        end
        CHK_PRESS: begin
          if (w_in) begin
            w_state_nxt = RELEASED;
          end else if (w_db_done) begin
            w_state_nxt = PRESSED;
            w_level_nxt = 1'b1;
            w_press_nxt = 1'b1;
            w_cnt_nxt   = '0;
`ifdef KEY_REPEAT_EN
            w_rep_first_nxt = 1'b1;
`endif
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        PRESSED: begin
          if (w_in) begin
            w_state_nxt = CHK_RELEASE;
            w_cnt_nxt   = '0;
          end
`ifdef KEY_REPEAT_EN
          else if (w_rep_due) begin
            w_press_nxt     = 1'b1;
            w_cnt_nxt       = '0;
            w_rep_first_nxt = 1'b0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
`endif
        end
        CHK_RELEASE: begin
          if (!w_in) begin
            w_state_nxt = PRESSED;
            w_cnt_nxt   = '0;
`ifdef KEY_REPEAT_EN
            w_rep_first_nxt = 1'b1;
`endif
          end else if (w_db_done) begin
            w_state_nxt = RELEASED;
            w_level_nxt = 1'b0;
            w_rel_nxt   = 1'b1;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        default: begin
          w_state_nxt = RELEASED;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    assign KEY_LEVEL[g]   = r_level;
    assign KEY_PRESS[g]   = r_press;
    assign KEY_RELEASE[g] = r_rel;
  end

  assign LEDG = KEY_LEVEL;

endmodule
